// File: rtl/etch_pen_ctl.sv
// -----------------------------------------------------------------------------
// etch_pen_ctl
//   Etch-a-Sketch pen sequencer. It sits between two rotary step decoders and
//   the LCD framebuffer.
//   - Integrates cw/ccw step pulses into a saturating (x,y) pen position.
//   - Plots the pen pixel into the framebuffer through an Avalon-MM write master.
//   - Sweeps the whole framebuffer with the background colour when asked to
//     (clear screen). The pen is redrawn once after every sweep.
//   - Owns the single framebuffer write port. Clear and draw traffic never
//     overlap, and at most one write is outstanding at any time.
//
// Ports
//   clk_clk          in   1       system clock
//   reset_reset_n    in   1       asynchronous active-low reset
//   x_cw / x_ccw     in   1       one-cycle step pulses, x axis
//   y_cw / y_ccw     in   1       one-cycle step pulses, y axis
//   clear_req        in   1       one-cycle pulse: request a screen clear
//   pen_colour       in   24      RGB888 draw colour, sampled when a draw issues
//   bg_colour        in   24      RGB888 clear colour, sampled on each clear write
//   avm_address      out  ADDR_W  framebuffer word address (y*WIDTH+x)
//   avm_write        out  1       write strobe
//   avm_writedata    out  24      pixel data
//   avm_waitrequest  in   1       slave stall
//   pos_x / pos_y    out  X_W/Y_W current pen position
//   busy             out  1       high whenever a draw or a sweep is in progress
// -----------------------------------------------------------------------------
module etch_pen_ctl #(
  parameter int WIDTH          = 800,
  parameter int HEIGHT         = 480,
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int ADDR_W         = 19,
  parameter int X_INIT         = 400,
  parameter int Y_INIT         = 240,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              x_cw,
  input  logic              x_ccw,
  input  logic              y_cw,
  input  logic              y_ccw,
  input  logic              clear_req,
  input  logic [23:0]       pen_colour,
  input  logic [23:0]       bg_colour,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [23:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic [X_W-1:0]    pos_x,
  output logic [Y_W-1:0]    pos_y,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR} state_t;

  localparam logic [X_W-1:0]    X_MAX     = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t              state, state_nxt;
  logic                dirty, dirty_nxt;
  logic                clear_pend, clear_pend_nxt;
  logic                write_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [23:0]         data_nxt;
  logic [X_W-1:0]      pos_x_nxt;
  logic [Y_W-1:0]      pos_y_nxt;

  // Position stepping. Opposing pulses on one axis cancel. A step that would
  // leave the screen is dropped, so it is not counted as movement.
  logic x_up, x_dn, y_up, y_dn, moved;
  assign x_up  = x_cw  & ~x_ccw & (pos_x != X_MAX);
  assign x_dn  = x_ccw & ~x_cw  & (pos_x != '0);
  assign y_up  = y_cw  & ~y_ccw & (pos_y != Y_MAX);
  assign y_dn  = y_ccw & ~y_cw  & (pos_y != '0);
  assign moved = x_up | x_dn | y_up | y_dn;

  assign pos_x_nxt = x_up ? pos_x + X_W'(1) : (x_dn ? pos_x - X_W'(1) : pos_x);
  assign pos_y_nxt = y_up ? pos_y + Y_W'(1) : (y_dn ? pos_y - Y_W'(1) : pos_y);

  // Both operands are widened to ADDR_W before the multiply so that the
  // product y*WIDTH cannot lose high bits.
  logic [ADDR_W-1:0] pen_addr;
  assign pen_addr = ADDR_W'(pos_y) * ADDR_W'(WIDTH) + ADDR_W'(pos_x);

  logic accept;
  assign accept = avm_write & ~avm_waitrequest;

  assign busy = (state != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without
    // these defaults, a path that does not assign a signal would infer a latch.
    state_nxt      = state;
    write_nxt      = avm_write;
    addr_nxt       = avm_address;
    data_nxt       = avm_writedata;
    dirty_nxt      = dirty | moved;
    clear_pend_nxt = clear_pend | (clear_req & (state != S_CLEAR));

    unique case (state)
      S_IDLE: begin
        if (clear_pend) begin
          state_nxt = S_CLEAR;
          write_nxt = 1'b1;
          addr_nxt  = '0;
          data_nxt  = bg_colour;
        end else if (dirty) begin
          state_nxt = S_DRAW;
          write_nxt = 1'b1;
          addr_nxt  = pen_addr;
          data_nxt  = pen_colour;
          // A step in this same cycle is not in the latched address, so that
          // step must keep dirty set.
          dirty_nxt = moved;
        end
      end
      S_DRAW: begin
        if (accept) begin
          state_nxt = S_IDLE;
          write_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        if (accept) begin
          if (avm_address == LAST_ADDR) begin
            state_nxt      = S_IDLE;
            write_nxt      = 1'b0;
            clear_pend_nxt = 1'b0;
            dirty_nxt      = 1'b1;
          end else begin
            addr_nxt = avm_address + ADDR_W'(1);
            data_nxt = bg_colour;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= S_IDLE;
      pos_x         <= X_W'(X_INIT);
      pos_y         <= Y_W'(Y_INIT);
      dirty         <= 1'b0;
      clear_pend    <= (CLEAR_ON_RESET != 0);
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register therefore samples values from before the clock edge.
      state         <= state_nxt;
      pos_x         <= pos_x_nxt;
      pos_y         <= pos_y_nxt;
      dirty         <= dirty_nxt;
      clear_pend    <= clear_pend_nxt;
      avm_write     <= write_nxt;
      avm_address   <= addr_nxt;
      avm_writedata <= data_nxt;
    end
  end

endmodule
